fetch_control_unit: RTL and testbench

//  Front-end controller sitting directly upstream of instruction_memory and downstream into execute.

---
 rtl/fetch_control_unit_if.sv | 31 +++
 rtl/fetch_control_unit.sv | 149 ++++++++++++++
 tb/tb_fetch_control_unit.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_control_unit_if.sv
// Bundles the fetch-side memory handshake, the decode valid/ready channel and the redirect/status lines.
// The fetch unit uses the master view; the memory/execute environment uses the slave view.
interface fetch_control_unit_if;
   logic [7:0]  pc;
   logic        fetch_enable;
   logic [19:0] instruction;
   logic        instruction_ready;
   logic        dec_valid;
   logic        dec_ready;
   logic [3:0]  dec_opcode;
   logic [3:0]  dec_rd;
   logic [3:0]  dec_rs;
   logic [7:0]  dec_imm;
   logic [7:0]  dec_pc;
   logic        redirect_valid;
   logic [7:0]  redirect_pc;
   logic        halted;
   logic        fetch_error;

   modport master (
      output pc, fetch_enable, dec_valid, dec_opcode, dec_rd, dec_rs, dec_imm, dec_pc,
             halted, fetch_error,
      input  instruction, instruction_ready, dec_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  pc, fetch_enable, dec_valid, dec_opcode, dec_rd, dec_rs, dec_imm, dec_pc,
             halted, fetch_error,
      output instruction, instruction_ready, dec_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/fetch_control_unit.sv
// Front-end fetch controller: owns the pc, requests words from instruction memory, presents decoded
// fields to execute over valid/ready, and handles redirects, HALT and a fetch watchdog.
module fetch_control_unit #(
   parameter logic [7:0] RESET_PC      = 8'h00,
   parameter logic [7:0] PC_STEP       = 8'd3,
   parameter logic [3:0] HALT_OPCODE   = 4'hF,
   parameter int         FETCH_TIMEOUT = 16
) (
   input logic                  clk,
   input logic                  rst,
   fetch_control_unit_if.master bus
);

   localparam int WDOG_W = $clog2(FETCH_TIMEOUT);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(FETCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      BOOT,
      F_REQ,
      F_WAIT,
      D_HOLD,
      HALTED
   } state_t;

   state_t            state;
   logic [7:0]        pc;
   logic              fetch_enable;
   logic              dec_valid;
   logic [3:0]        dec_opcode;
   logic [3:0]        dec_rd;
   logic [3:0]        dec_rs;
   logic [7:0]        dec_imm;
   logic [7:0]        dec_pc;
   logic              halted;
   logic              fetch_error;
   logic              redirect_pend;
   logic [7:0]        redirect_target;
   logic [WDOG_W-1:0] wdog;

   assign bus.pc           = pc;
   assign bus.fetch_enable = fetch_enable;
   assign bus.dec_valid    = dec_valid;
   assign bus.dec_opcode   = dec_opcode;
   assign bus.dec_rd       = dec_rd;
   assign bus.dec_rs       = dec_rs;
   assign bus.dec_imm      = dec_imm;
   assign bus.dec_pc       = dec_pc;
   assign bus.halted       = halted;
   assign bus.fetch_error  = fetch_error;

   // Every output is registered; fetch_enable and fetch_error default low so they act as one-cycle pulses
   // raised only on the edge that enters F_REQ.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= BOOT;
         pc              <= RESET_PC;
         fetch_enable    <= 1'b0;
         dec_valid       <= 1'b0;
         dec_opcode      <= 4'h0;
         dec_rd          <= 4'h0;
         dec_rs          <= 4'h0;
         dec_imm         <= 8'h00;
         dec_pc          <= 8'h00;
         halted          <= 1'b0;
         fetch_error     <= 1'b0;
         redirect_pend   <= 1'b0;
         redirect_target <= 8'h00;
         wdog            <= '0;
      end else begin
         fetch_enable <= 1'b0;
         fetch_error  <= 1'b0;
         case (state)
            BOOT: begin
               state        <= F_REQ;
               fetch_enable <= 1'b1;
            end
            F_REQ: begin
               wdog  <= '0;
               state <= F_WAIT;
               if (bus.redirect_valid) begin
                  redirect_pend   <= 1'b1;
                  redirect_target <= bus.redirect_pc;
               end
            end
            F_WAIT: begin
               // The memory cannot abort a fetch, so a redirect only takes effect once the word returns.
               if (bus.instruction_ready) begin
                  if (redirect_pend || bus.redirect_valid) begin
                     pc            <= bus.redirect_valid ? bus.redirect_pc : redirect_target;
                     redirect_pend <= 1'b0;
                     state         <= F_REQ;
                     fetch_enable  <= 1'b1;
                  end else begin
                     dec_opcode <= bus.instruction[19:16];
                     dec_rd     <= bus.instruction[15:12];
                     dec_rs     <= bus.instruction[11:8];
                     dec_imm    <= bus.instruction[7:0];
                     dec_pc     <= pc;
                     dec_valid  <= 1'b1;
                     state      <= D_HOLD;
                  end
               end else begin
                  if (bus.redirect_valid) begin
                     redirect_pend   <= 1'b1;
                     redirect_target <= bus.redirect_pc;
                  end
                  if (wdog == WDOG_LAST) begin
                     fetch_error  <= 1'b1;
                     fetch_enable <= 1'b1;
                     state        <= F_REQ;
                  end else begin
                     wdog <= wdog + 1'b1;
                  end
               end
            end
            D_HOLD: begin
               // A redirect beats a same-cycle dec_ready: the held instruction is dropped unaccepted.
               if (bus.redirect_valid) begin
                  dec_valid     <= 1'b0;
                  pc            <= bus.redirect_pc;
                  redirect_pend <= 1'b0;
                  state         <= F_REQ;
                  fetch_enable  <= 1'b1;
               end else if (bus.dec_ready) begin
                  dec_valid <= 1'b0;
                  if (dec_opcode == HALT_OPCODE) begin
                     halted <= 1'b1;
                     state  <= HALTED;
                  end else begin
                     pc           <= pc + PC_STEP;
                     state        <= F_REQ;
                     fetch_enable <= 1'b1;
                  end
               end
            end
            HALTED: begin
               if (bus.redirect_valid) begin
                  halted       <= 1'b0;
                  pc           <= bus.redirect_pc;
                  state        <= F_REQ;
                  fetch_enable <= 1'b1;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_control_unit.sv
// Bench for fetch_control_unit: a 4-cycle instruction memory stub, directed scenario tasks and a
// randomized run scored against a next-expected-pc model of the instruction stream.
module tb_fetch_control_unit;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_control_unit_if bus();

   fetch_control_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem [256];
   int errors = 0;
   int checks = 0;
   int stub_drop = 0;
   int stub_cnt = 0;
   logic [7:0] stub_addr = 8'h00;

   function automatic logic [19:0] word_at(input logic [7:0] a);
      logic [7:0] a1;
      logic [7:0] a2;
      a1 = a + 8'd1;
      a2 = a + 8'd2;
      return {mem[a2][3:0], mem[a1], mem[a]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_dec_valid(input int limit, output bit found);
      for (int i = 0; i < limit && !bus.dec_valid; i++) tick();
      found = bus.dec_valid;
   endtask

   // Memory stub: a request seen in cycle N is answered with a one-cycle ready strobe in cycle N+4.
   initial begin
      bus.instruction       = 20'h0;
      bus.instruction_ready = 1'b0;
      forever begin
         tick();
         bus.instruction_ready = 1'b0;
         if (rst) begin
            stub_cnt = 0;
         end else if (bus.fetch_enable) begin
            if (stub_drop > 0) begin
               stub_drop--;
               stub_cnt = 0;
            end else begin
               stub_cnt  = 4;
               stub_addr = bus.pc;
            end
         end else if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
               checks++;
               if (bus.pc !== stub_addr) begin
                  errors++;
                  $display("[TB] FAIL pc_stable: pc=%h during fetch, required %h", bus.pc, stub_addr);
               end
               bus.instruction       = word_at(stub_addr);
               bus.instruction_ready = 1'b1;
            end
         end
      end
   end

   task automatic test_reset();
      int fe_cycle;
      int fe_count;
      int dv_cycle;
      mem[0] = 8'h34;
      mem[1] = 8'h12;
      mem[2] = 8'hA5;
      rst = 1'b1;
      bus.dec_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if ({bus.pc, bus.fetch_enable, bus.dec_valid, bus.halted, bus.fetch_error, bus.dec_opcode,
           bus.dec_rd, bus.dec_rs, bus.dec_imm, bus.dec_pc} !== 48'h0) begin
         errors++;
         $display("[TB] FAIL reset_state: pc=%h fe=%b dv=%b halted=%b ferr=%b dec_pc=%h, required all zero",
                  bus.pc, bus.fetch_enable, bus.dec_valid, bus.halted, bus.fetch_error, bus.dec_pc);
      end
      rst = 1'b0;
      fe_cycle = -1;
      fe_count = 0;
      dv_cycle = -1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (bus.fetch_enable) begin
            fe_count++;
            if (fe_cycle < 0) fe_cycle = c;
         end
         if (bus.dec_valid && dv_cycle < 0) dv_cycle = c;
      end
      checks++;
      if (fe_cycle != 1 || fe_count != 1) begin
         errors++;
         $display("[TB] FAIL boot_fetch: first fetch cycle %0d count %0d, required cycle 1 count 1",
                  fe_cycle, fe_count);
      end
      checks++;
      if (dv_cycle != 6) begin
         errors++;
         $display("[TB] FAIL first_dec_valid: cycle %0d, required 6", dv_cycle);
      end
      // Word is {A5[3:0], 12, 34}: the upper nibble of byte2 is not part of the instruction.
      checks++;
      if ({bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm, bus.dec_pc} !== 28'h5_1_2_34_00) begin
         errors++;
         $display("[TB] FAIL first_fields: op=%h rd=%h rs=%h imm=%h pc=%h, required op=5 rd=1 rs=2 imm=34 pc=00",
                  bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm, bus.dec_pc);
      end
   endtask

   task automatic test_hold();
      int bad;
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (!bus.dec_valid || bus.fetch_enable ||
             {bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm, bus.dec_pc} !== 28'h5_1_2_34_00) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL hold_stable: %0d unstable cycles, required 0", bad);
      end
      bus.dec_ready = 1'b1;
      tick();
      bus.dec_ready = 1'b0;
      checks++;
      if (bus.pc !== 8'h03 || bus.fetch_enable !== 1'b1 || bus.dec_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL accept_advance: pc=%h fe=%b dv=%b, required pc=03 fe=1 dv=0",
                  bus.pc, bus.fetch_enable, bus.dec_valid);
      end
   endtask

   task automatic test_redirect_wait();
      bit seen_fetch;
      bit early_valid;
      logic [7:0] fetch_pc;
      bit found;
      mem[8'h40] = 8'h78;
      mem[8'h41] = 8'h56;
      mem[8'h42] = 8'h03;
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'h40;
      tick();
      bus.redirect_valid = 1'b0;
      seen_fetch  = 1'b0;
      early_valid = 1'b0;
      fetch_pc    = 8'h00;
      for (int c = 0; c < 12 && !seen_fetch; c++) begin
         if (bus.dec_valid) early_valid = 1'b1;
         if (bus.fetch_enable) begin
            seen_fetch = 1'b1;
            fetch_pc   = bus.pc;
         end else begin
            tick();
         end
      end
      checks++;
      if (early_valid || !seen_fetch || fetch_pc !== 8'h40) begin
         errors++;
         $display("[TB] FAIL redirect_wait_fetch: early_dv=%b fetched=%b pc=%h, required 0,1,40",
                  early_valid, seen_fetch, fetch_pc);
      end
      wait_dec_valid(10, found);
      checks++;
      if (!found || bus.dec_pc !== 8'h40 || bus.dec_opcode !== 4'h3 || bus.dec_imm !== 8'h78) begin
         errors++;
         $display("[TB] FAIL redirect_wait_dec: dv=%b dec_pc=%h op=%h imm=%h, required 1,40,3,78",
                  found, bus.dec_pc, bus.dec_opcode, bus.dec_imm);
      end
   endtask

   task automatic test_redirect_accept();
      bit found;
      mem[8'h80] = 8'h11;
      mem[8'h81] = 8'h22;
      mem[8'h82] = 8'h07;
      bus.dec_ready      = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'h80;
      tick();
      bus.dec_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.dec_valid !== 1'b0 || bus.pc !== 8'h80 || bus.fetch_enable !== 1'b1) begin
         errors++;
         $display("[TB] FAIL redirect_beats_accept: dv=%b pc=%h fe=%b, required 0,80,1",
                  bus.dec_valid, bus.pc, bus.fetch_enable);
      end
      wait_dec_valid(10, found);
      checks++;
      if (!found || bus.dec_pc !== 8'h80 || bus.dec_opcode !== 4'h7) begin
         errors++;
         $display("[TB] FAIL redirect_accept_dec: dv=%b dec_pc=%h op=%h, required 1,80,7",
                  found, bus.dec_pc, bus.dec_opcode);
      end
   endtask

   task automatic test_halt();
      bit found;
      int bad;
      mem[8'h20] = 8'hAB;
      mem[8'h21] = 8'hCD;
      mem[8'h22] = 8'h0F;
      mem[8'h10] = 8'h01;
      mem[8'h11] = 8'h02;
      mem[8'h12] = 8'h03;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'h20;
      tick();
      bus.redirect_valid = 1'b0;
      wait_dec_valid(10, found);
      checks++;
      if (!found || bus.dec_opcode !== 4'hF || bus.dec_pc !== 8'h20) begin
         errors++;
         $display("[TB] FAIL halt_present: dv=%b op=%h dec_pc=%h, required 1,F,20",
                  found, bus.dec_opcode, bus.dec_pc);
      end
      bus.dec_ready = 1'b1;
      tick();
      bus.dec_ready = 1'b0;
      checks++;
      if (bus.halted !== 1'b1 || bus.dec_valid !== 1'b0 || bus.fetch_enable !== 1'b0) begin
         errors++;
         $display("[TB] FAIL halt_enter: halted=%b dv=%b fe=%b, required 1,0,0",
                  bus.halted, bus.dec_valid, bus.fetch_enable);
      end
      bad = 0;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (bus.fetch_enable || !bus.halted || bus.pc !== 8'h20) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL halt_idle: %0d cycles fetched or left halt, required 0", bad);
      end
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'h10;
      tick();
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.halted !== 1'b0 || bus.fetch_enable !== 1'b1 || bus.pc !== 8'h10) begin
         errors++;
         $display("[TB] FAIL halt_resume: halted=%b fe=%b pc=%h, required 0,1,10",
                  bus.halted, bus.fetch_enable, bus.pc);
      end
      wait_dec_valid(10, found);
      checks++;
      if (!found || bus.dec_pc !== 8'h10 || bus.dec_opcode !== 4'h3) begin
         errors++;
         $display("[TB] FAIL halt_resume_dec: dv=%b dec_pc=%h op=%h, required 1,10,3",
                  found, bus.dec_pc, bus.dec_opcode);
      end
   endtask

   task automatic test_timeout();
      int err_cycle;
      int err_count;
      int early_fe;
      logic [7:0] err_pc;
      logic err_fe;
      bit found;
      mem[8'hFE] = 8'h9A;
      mem[8'hFF] = 8'hBC;
      stub_drop = 1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 8'hFE;
      tick();
      bus.redirect_valid = 1'b0;
      checks++;
      if (bus.fetch_enable !== 1'b1 || bus.pc !== 8'hFE) begin
         errors++;
         $display("[TB] FAIL timeout_first_fetch: fe=%b pc=%h, required 1,FE", bus.fetch_enable, bus.pc);
      end
      err_cycle = -1;
      err_count = 0;
      early_fe  = 0;
      err_pc    = 8'h00;
      err_fe    = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c <= 16 && bus.fetch_enable) early_fe++;
         if (bus.fetch_error) begin
            err_count++;
            if (err_cycle < 0) begin
               err_cycle = c;
               err_pc    = bus.pc;
               err_fe    = bus.fetch_enable;
            end
         end
      end
      // 16 waiting cycles follow the request; the error pulse coincides with the re-request.
      checks++;
      if (err_cycle != 17 || err_count != 1 || early_fe != 0) begin
         errors++;
         $display("[TB] FAIL timeout_pulse: cycle %0d count %0d early_fetches %0d, required 17,1,0",
                  err_cycle, err_count, early_fe);
      end
      checks++;
      if (err_fe !== 1'b1 || err_pc !== 8'hFE) begin
         errors++;
         $display("[TB] FAIL timeout_refetch: fe=%b pc=%h, required 1,FE", err_fe, err_pc);
      end
      wait_dec_valid(10, found);
      checks++;
      if (!found || {bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm, bus.dec_pc} !== 28'h4_B_C_9A_FE) begin
         errors++;
         $display("[TB] FAIL wrap_fields: dv=%b op=%h rd=%h rs=%h imm=%h pc=%h, required 4,B,C,9A,FE",
                  found, bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm, bus.dec_pc);
      end
      bus.dec_ready = 1'b1;
      tick();
      bus.dec_ready = 1'b0;
      checks++;
      if (bus.pc !== 8'h01 || bus.fetch_enable !== 1'b1) begin
         errors++;
         $display("[TB] FAIL pc_wrap: pc=%h fe=%b, required 01,1", bus.pc, bus.fetch_enable);
      end
   endtask

   // Model: the next presented instruction comes from the latest redirect target, else from the
   // previously accepted pc plus 3, and its fields are the memory word at that pc.
   task automatic test_random();
      logic [7:0] exp_pc;
      logic [19:0] w;
      bit prev_hold;
      int since_acc;
      int idle;
      int ferr_seen;
      rst = 1'b1;
      bus.dec_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 14))};
      rst = 1'b0;
      exp_pc    = 8'h00;
      prev_hold = 1'b0;
      since_acc = -1;
      idle      = 0;
      ferr_seen = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         tick();
         if (since_acc >= 0) since_acc++;
         if (bus.fetch_error) ferr_seen++;
         if (prev_hold) begin
            checks++;
            if (bus.dec_valid !== 1'b1) begin
               errors++;
               $display("[TB] FAIL rand_hold: dec_valid=%b at cycle %0d, required 1", bus.dec_valid, cyc);
            end
         end
         if (bus.dec_valid) begin
            idle = 0;
            w = word_at(exp_pc);
            checks++;
            if ({bus.dec_pc, bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm} !== {exp_pc, w}) begin
               errors++;
               $display("[TB] FAIL rand_dec: pc=%h word=%h, required pc=%h word=%h",
                        bus.dec_pc, {bus.dec_opcode, bus.dec_rd, bus.dec_rs, bus.dec_imm}, exp_pc, w);
            end
            if (since_acc >= 0) begin
               checks++;
               if (since_acc != 6) begin
                  errors++;
                  $display("[TB] FAIL rand_latency: %0d cycles accept-to-valid, required 6", since_acc);
               end
               since_acc = -1;
            end
         end else begin
            idle++;
            if (idle > 30) begin
               checks++;
               errors++;
               $display("[TB] FAIL rand_liveness: no dec_valid for %0d cycles, required at most 30", idle);
               break;
            end
         end
         bus.redirect_valid = 1'b0;
         bus.dec_ready      = 1'b0;
         if (cyc > 4 && $urandom_range(0, 19) == 0) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 8'($urandom);
            exp_pc    = bus.redirect_pc;
            since_acc = -1;
            prev_hold = 1'b0;
         end else begin
            bus.dec_ready = 1'($urandom_range(0, 1));
            if (bus.dec_valid && bus.dec_ready) begin
               exp_pc    = exp_pc + 8'd3;
               since_acc = 0;
               prev_hold = 1'b0;
            end else begin
               prev_hold = bus.dec_valid;
            end
         end
      end
      bus.redirect_valid = 1'b0;
      bus.dec_ready      = 1'b0;
      checks++;
      if (ferr_seen != 0) begin
         errors++;
         $display("[TB] FAIL rand_no_timeout: %0d fetch_error pulses, required 0", ferr_seen);
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.dec_ready      = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      test_reset();
      test_hold();
      test_redirect_wait();
      test_redirect_accept();
      test_halt();
      test_timeout();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("[TB] FAIL global_timeout: bench still running at %0t, required completion", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "[TB] time limit reached");
   end

endmodule
